// File: rtl/udp_tx_pkg.sv
// Shared types and word-format helpers for the UDP transmit pattern generator.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_GAP
  } state_t;

  // word0 carries the sequence and length, word1 the timestamp
  localparam int HDR_WORDS = 2;

  function automatic logic [31:0] hdr_word(input logic [15:0] seq_lo, input logic [15:0] len);
    return {seq_lo, len};
  endfunction

  function automatic logic [31:0] fill_word(input logic [15:0] seq_lo, input logic [15:0] idx);
    return {seq_lo, idx};
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] cfg, input logic [15:0] min_len,
                                            input logic [15:0] max_len);
    if (cfg < min_len) return min_len;
    if (cfg > max_len) return max_len;
    return cfg;
  endfunction

  function automatic logic limit_ok(input logic [31:0] frames, input logic [31:0] limit);
    return (limit == 32'd0) || (frames < limit);
  endfunction

endpackage

// File: rtl/udp_tx_pattern_gen.sv
// UDP send-channel traffic source: sequenced, timestamped frames separated by a
// programmable gap, with request timeout and frame/timeout statistics.
module udp_tx_pattern_gen
  import udp_tx_pkg::*;
#(
  parameter int MAX_WORDS   = 1024,
  parameter int ACK_TIMEOUT = 4096,
  parameter int MIN_WORDS   = 2
) (
  input  logic        pUPLGlobalClk,
  input  logic        Reset_n,
  input  logic        run,
  input  logic [15:0] cfg_len_words,
  input  logic [31:0] cfg_gap_cycles,
  input  logic [31:0] cfg_frame_limit,
  output logic [31:0] pUdpSend_Data,
  output logic        pUdpSend_Request,
  input  logic        pUdpSend_Ack,
  output logic        pUdpSend_Enable,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [15:0] ack_timeouts
);

  localparam logic [15:0] MIN_LEN  = 16'(MIN_WORDS);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_WORDS);
  localparam logic [15:0] HDR_LEN  = 16'(HDR_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] seq, seq_nxt;
  logic [31:0] ts;
  logic [31:0] gap_cnt, gap_nxt;
  logic [31:0] tmo, tmo_nxt;
  logic [31:0] frames_nxt, frames_eff;
  logic [31:0] data_nxt;
  logic [15:0] len, len_nxt;
  logic [15:0] idx, idx_nxt;
  logic [15:0] timeouts_nxt;
  logic        run_d, run_rise;
  logic        req_nxt, en_nxt;

  // A fresh run starts its statistics from zero, so the limit check must see that too
  assign run_rise   = run & ~run_d;
  assign frames_eff = run_rise ? 32'd0 : frames_sent;

  always_comb begin
    state_nxt    = state;
    seq_nxt      = seq;
    len_nxt      = len;
    idx_nxt      = idx;
    gap_nxt      = gap_cnt;
    tmo_nxt      = tmo;
    frames_nxt   = frames_sent;
    timeouts_nxt = ack_timeouts;
    data_nxt     = 32'd0;
    req_nxt      = 1'b0;
    en_nxt       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run_rise) begin
          frames_nxt   = 32'd0;
          timeouts_nxt = 16'd0;
        end
        if (run && limit_ok(frames_eff, cfg_frame_limit)) begin
          state_nxt = ST_REQ;
          len_nxt   = clamp_len(cfg_len_words, MIN_LEN, MAX_LEN);
          tmo_nxt   = 32'd0;
          req_nxt   = 1'b1;
        end
      end

      ST_REQ: begin
        if (pUdpSend_Ack) begin
          state_nxt = ST_SEND;
          en_nxt    = 1'b1;
          data_nxt  = hdr_word(seq[15:0], len);
          idx_nxt   = 16'd1;
        end else if (tmo == TMO_LAST) begin
          state_nxt = ST_GAP;
          gap_nxt   = cfg_gap_cycles;
          if (ack_timeouts != 16'hFFFF) timeouts_nxt = ack_timeouts + 16'd1;
        end else begin
          tmo_nxt = tmo + 32'd1;
          req_nxt = 1'b1;
        end
      end

      // ts sampled here is the value seen during the word0 cycle
      ST_SEND: begin
        if (idx == len) begin
          state_nxt  = ST_GAP;
          gap_nxt    = cfg_gap_cycles;
          seq_nxt    = seq + 32'd1;
          frames_nxt = frames_sent + 32'd1;
        end else begin
          en_nxt   = 1'b1;
          idx_nxt  = idx + 16'd1;
          data_nxt = (idx < HDR_LEN) ? ts : fill_word(seq[15:0], idx);
        end
      end

      ST_GAP: begin
        if (gap_cnt == 32'd0) begin
          if (run && limit_ok(frames_sent, cfg_frame_limit)) begin
            state_nxt = ST_REQ;
            len_nxt   = clamp_len(cfg_len_words, MIN_LEN, MAX_LEN);
            tmo_nxt   = 32'd0;
            req_nxt   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - 32'd1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pUPLGlobalClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= ST_IDLE;
      seq              <= 32'd0;
      ts               <= 32'd0;
      len              <= 16'd0;
      idx              <= 16'd0;
      gap_cnt          <= 32'd0;
      tmo              <= 32'd0;
      run_d            <= 1'b0;
      frames_sent      <= 32'd0;
      ack_timeouts     <= 16'd0;
      pUdpSend_Data    <= 32'd0;
      pUdpSend_Request <= 1'b0;
      pUdpSend_Enable  <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      seq              <= seq_nxt;
      ts               <= ts + 32'd1;
      len              <= len_nxt;
      idx              <= idx_nxt;
      gap_cnt          <= gap_nxt;
      tmo              <= tmo_nxt;
      run_d            <= run;
      frames_sent      <= frames_nxt;
      ack_timeouts     <= timeouts_nxt;
      pUdpSend_Data    <= data_nxt;
      pUdpSend_Request <= req_nxt;
      pUdpSend_Enable  <= en_nxt;
      busy             <= (state_nxt != ST_IDLE);
    end
  end

endmodule
